// File: rtl/vector_wb_arbiter.sv
// Round-robin arbiter for the vector register file write port, with a one-entry result register.
// Grant to wb_valid takes 1 cycle. While wb_valid=1 and wb_ready=0, gnt stays zero and wb_* hold.
module vector_wb_arbiter #(
   parameter int NUM_UNITS = 5,
   parameter int DATA_W    = 128
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_UNITS-1:0]        req,
   input  logic [NUM_UNITS*5-1:0]      req_dest,
   input  logic [NUM_UNITS*7-1:0]      req_ref,
   input  logic [NUM_UNITS*DATA_W-1:0] req_data,
   output logic [NUM_UNITS-1:0]        gnt,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [4:0]                  wb_dest,
   output logic [6:0]                  wb_ref,
   output logic [4:0]                  wb_unit,
   output logic [DATA_W-1:0]           wb_data,
   output logic [7:0]                  stall_max
);

   localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [PW:0]   NUM_U = (PW+1)'(NUM_UNITS);
   localparam logic [PW-1:0] LAST  = PW'(NUM_UNITS - 1);

   typedef struct packed {
      logic [4:0]        dest;
      logic [6:0]        rs_ref;
      logic [4:0]        unit;
      logic [DATA_W-1:0] data;
   } wb_t;

   logic [4:0]        dest_arr [NUM_UNITS];
   logic [6:0]        ref_arr  [NUM_UNITS];
   logic [DATA_W-1:0] data_arr [NUM_UNITS];
   logic [7:0]        wait_cnt [NUM_UNITS];

   logic [PW-1:0] ptr, ptr_next, winner, idx;
   logic [PW:0]   sum;
   logic          found, accept, valid_q;
   logic [7:0]    max_wait;
   wb_t           wb_q, wb_d;

   for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
      assign dest_arr[g] = req_dest[5*g +: 5];
      assign ref_arr[g]  = req_ref[7*g +: 7];
      assign data_arr[g] = req_data[DATA_W*g +: DATA_W];
   end

   assign accept = !valid_q || wb_ready;

   // First requester at or after ptr, wrapping modulo NUM_UNITS.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= NUM_U) sum = sum - NUM_U;
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (!reset && accept && found) gnt[winner] = 1'b1;
   end

   always_comb begin
      ptr_next    = (winner == LAST) ? '0 : winner + PW'(1);
      wb_d.dest   = dest_arr[winner];
      wb_d.rs_ref = ref_arr[winner];
      wb_d.unit   = 5'b00001 << winner;
      wb_d.data   = data_arr[winner];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr     <= '0;
         valid_q <= 1'b0;
         wb_q    <= '0;
      end else if (accept) begin
         if (found) begin
            ptr     <= ptr_next;
            valid_q <= 1'b1;
            wb_q    <= wb_d;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   // stall_max tracks the registered counters, so it lags a unit's wait by one cycle.
   always_comb begin
      max_wait = stall_max;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_UNITS; i++) wait_cnt[i] <= '0;
         stall_max <= '0;
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (req[i] && !gnt[i]) begin
               if (wait_cnt[i] != 8'hFF) wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end else begin
               wait_cnt[i] <= '0;
            end
         end
         stall_max <= max_wait;
      end
   end

   assign wb_valid = valid_q;
   assign wb_dest  = wb_q.dest;
   assign wb_ref   = wb_q.rs_ref;
   assign wb_unit  = wb_q.unit;
   assign wb_data  = wb_q.data;

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Directed bench for vector_wb_arbiter: reset, round-robin order, payload capture, back-pressure, wrap, async reset.
module tb_vector_wb_arbiter;

   localparam int NU = 5;
   localparam int DW = 128;

   logic              clk = 1'b0;
   logic              reset;
   logic [NU-1:0]     req;
   logic [NU*5-1:0]   req_dest;
   logic [NU*7-1:0]   req_ref;
   logic [NU*DW-1:0]  req_data;
   logic [NU-1:0]     gnt;
   logic              wb_valid;
   logic              wb_ready;
   logic [4:0]        wb_dest;
   logic [6:0]        wb_ref;
   logic [4:0]        wb_unit;
   logic [DW-1:0]     wb_data;
   logic [7:0]        stall_max;

   logic [4:0]    dest_t [NU];
   logic [6:0]    ref_t  [NU];
   logic [DW-1:0] data_t [NU];

   int n_checks = 0;
   int n_fails  = 0;

   vector_wb_arbiter #(.NUM_UNITS(NU), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .req_ref(req_ref),
      .req_data(req_data), .gnt(gnt), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_dest(wb_dest), .wb_ref(wb_ref), .wb_unit(wb_unit), .wb_data(wb_data),
      .stall_max(stall_max)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NU; i++) begin
         req_dest[5*i +: 5]   = dest_t[i];
         req_ref[7*i +: 7]    = ref_t[i];
         req_data[DW*i +: DW] = data_t[i];
      end
   end

   function automatic logic [4:0] def_dest(input int i);
      return 5'(10 + i);
   endfunction
   function automatic logic [6:0] def_ref(input int i);
      return {3'(i), 4'(i + 2)};
   endfunction
   function automatic logic [DW-1:0] def_data(input int i);
      return {4{32'hC0DE_0000 | 32'(i)}};
   endfunction

   task automatic load_defaults();
      for (int i = 0; i < NU; i++) begin
         dest_t[i] = def_dest(i);
         ref_t[i]  = def_ref(i);
         data_t[i] = def_data(i);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_wb(input string tag, input int u);
      check({tag, " valid"}, wb_valid, 1'b1);
      check({tag, " unit"},  wb_unit,  5'b00001 << u);
      check({tag, " dest"},  wb_dest,  dest_t[u]);
      check({tag, " ref"},   wb_ref,   ref_t[u]);
      check({tag, " data"},  wb_data,  data_t[u]);
   endtask

   initial begin
      load_defaults();
      reset    = 1'b1;
      req      = 5'b11111;
      wb_ready = 1'b1;
      tick();
      tick();
      check("rst gnt",       gnt,       5'b00000);
      check("rst wb_valid",  wb_valid,  1'b0);
      check("rst wb_dest",   wb_dest,   5'd0);
      check("rst wb_ref",    wb_ref,    7'd0);
      check("rst wb_unit",   wb_unit,   5'd0);
      check("rst wb_data",   wb_data,   '0);
      check("rst stall_max", stall_max, 8'd0);

      // Release: MADD first, then strict rotation with no bubbles.
      reset = 1'b0;
      #1;
      check("first gnt", gnt, 5'b00001);
      tick();
      check_wb("first wb", 0);
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("rr gnt %0d", k), gnt, 5'b00001 << (k % 5));
         tick();
         check($sformatf("rr unit %0d", k), wb_unit, 5'b00001 << (k % 5));
         check($sformatf("rr valid %0d", k), wb_valid, 1'b1);
      end
      check("rr stall_max", stall_max, 8'd4);

      // Only PLS requests, with a distinctive payload.
      req       = 5'b01000;
      dest_t[3] = 5'd17;
      ref_t[3]  = {3'b011, 4'd9};
      data_t[3] = {16{8'hA5}};
      #1;
      check("pls gnt", gnt, 5'b01000);
      tick();
      check_wb("pls wb", 3);
      check("pls ref value", wb_ref, 7'h39);

      // ptr now at PERMUTE: full request set picks PERMUTE.
      load_defaults();
      req = 5'b11111;
      #1;
      check("ptr at permute", gnt, 5'b10000);

      // Wrap from 4 to 0.
      req = 5'b00011;
      #1;
      check("wrap gnt madd", gnt, 5'b00001);
      tick();
      check_wb("wrap wb madd", 0);
      check("wrap gnt cmp", gnt, 5'b00010);
      tick();
      check_wb("wrap wb cmp", 1);

      // Back-pressure: CMP result held for three cycles.
      wb_ready = 1'b0;
      req      = 5'b00110;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp gnt %0d", k), gnt, 5'b00000);
         tick();
         check_wb($sformatf("bp hold %0d", k), 1);
      end
      wb_ready = 1'b1;
      #1;
      check("bp release gnt", gnt, 5'b00100);
      tick();
      check_wb("bp release wb", 2);
      check("bp next gnt", gnt, 5'b00010);
      tick();
      check_wb("bp next wb", 1);
      check("bp stall_max", stall_max, 8'd4);

      // Idle with accept: register drains.
      req = 5'b00000;
      #1;
      check("idle gnt", gnt, 5'b00000);
      tick();
      check("idle valid", wb_valid, 1'b0);

      // Async reset with a held result.
      req = 5'b00100;
      #1;
      tick();
      check_wb("pre-reset wb", 2);
      wb_ready = 1'b0;
      req      = 5'b11111;
      #2;
      reset = 1'b1;
      #1;
      check("async valid",     wb_valid,  1'b0);
      check("async dest",      wb_dest,   5'd0);
      check("async gnt",       gnt,       5'b00000);
      check("async stall_max", stall_max, 8'd0);
      tick();
      reset    = 1'b0;
      wb_ready = 1'b1;
      #1;
      check("post-reset gnt", gnt, 5'b00001);
      tick();
      check_wb("post-reset wb", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/vector_wb_arbiter.md
# vector_wb_arbiter

Shares the single vector register file write port between the NUM_UNITS vector functional units: multiply-add, compare, load/store, parallel load/store and permute. Each cycle it selects at most one pending result by round-robin and captures it in a one-entry output register. It then presents that result to the VRF write port and broadcasts it on the result bus, tagged with its reservation-station reference. The block sits between the unit result stages and the VRF/reservation-station wakeup logic of the vector pipeline.

## Interface
- NUM_UNITS, 5, number of requesting units; index i equals the Unit_id encoding (0 MADD, 1 CMP, 2 LS, 3 PLS, 4 PERMUTE)
- DATA_W, 128, result width in bits
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_UNITS  unit i has a result pending
- req_dest  in  NUM_UNITS*5  Vrf_index of unit i at bits [5i+4:5i]
- req_ref  in  NUM_UNITS*7  Rs_ref (unit id, entry) of unit i at bits [7i+6:7i]
- req_data  in  NUM_UNITS*DATA_W  result of unit i
- gnt  out  NUM_UNITS  one-hot; unit i's result is accepted this cycle
- wb_valid  out  1  output register holds a result
- wb_ready  in  1  VRF port consumes the result this cycle
- wb_dest  out  5  Vrf_index being written
- wb_ref  out  7  Rs_ref of the producing operation
- wb_unit  out  5  one-hot Unit of the producer (unit_id_to_unit of the winner)
- wb_data  out  DATA_W  result data
- stall_max  out  8  largest number of consecutive cycles any unit has waited since reset, saturating at 255

## Operation
- Accept condition: accept = !wb_valid || wb_ready. When accept=0, gnt is all-zero and the output register holds.
- Arbitration: a round-robin pointer ptr in 0..NUM_UNITS-1 selects the winner, which is the first i with req[i] set, searching ptr, ptr+1, … with wrap modulo NUM_UNITS.
  - If accept=1 and any req is set, gnt[winner]=1. gnt is combinational from req, ptr and accept.
- On a grant, the output register loads the winner's dest, ref, data and unit, and sets wb_valid=1. ptr becomes (winner+1) mod NUM_UNITS; the wrap from 4 goes to 0.
- If accept=1 and no req is set, wb_valid becomes 0 and ptr is unchanged.
- Simultaneous consume and grant in the same cycle: the register reloads with the new winner and wb_valid stays 1. There is no bubble.
- Units hold req and their payload stable until they see gnt. A request withdrawn before grant is legal and is simply not considered.
- Wait counters: each unit has a wait[i] counter, 8 bits, saturating.
  - wait[i] increments when req[i] is set and gnt[i] is not.
  - wait[i] clears when req[i] is clear or gnt[i] is set.
  - stall_max is updated to max(stall_max, wait[i]) every cycle.
- Round-robin bound: no unit waits more than NUM_UNITS−1 grants while accept is continuously 1.
- Reset: ptr=0, wb_valid=0, wb_dest=0, wb_ref=0, wb_unit=0, wb_data=0, all wait=0, stall_max=0. gnt is 0 while reset is asserted.
- Reset asserted mid-operation discards any held result; no write occurs for it.

## Timing
- Latency from grant to wb_valid: 1 cycle, registered.
- Sustained throughput is 1 result per cycle while wb_ready=1.
- wb_* outputs are registered and change only on rising edges where accept=1.
- The combinational path from wb_ready to gnt is permitted. The units' result stages must register gnt.
- Back-pressure: with wb_valid=1 and wb_ready=0, the outputs are held bit-stable for every stalled cycle.

## Test plan
- Reset with all req=1 → gnt=0 and wb_valid=0 during reset. In the first cycle after reset gnt=5'b00001 (MADD), and next cycle wb_valid=1, wb_unit=VU_MADD.
- All five req held high, wb_ready=1 → grants MADD, CMP, LS, PLS, PERMUTE, MADD in that order, one per cycle; wb_valid stays 1 with no bubbles; stall_max=4.
- Only PLS requests (dest=5'd17, ref={3'b011,4'd9}, data=0xA5…), wb_ready=1 → gnt=5'b01000, next cycle wb_dest=17, wb_ref=0x39, wb_unit=VU_PLS, and ptr points at PERMUTE.
- Result held with wb_ready=0 for 3 cycles while CMP and LS request → gnt=0 and outputs unchanged for 3 cycles. In the cycle wb_ready rises the next winner is granted and loaded with no bubble.
- ptr=4 with req=5'b00011 → MADD granted first (wrap from 4 to 0), then CMP.
- Assert reset while wb_valid=1, wb_ready=0 → wb_valid=0 immediately and asynchronously, with no write; after release, arbitration resumes from ptr=0.
